// File: rtl/area_scan_sched.sv
// Shares one CUDB write port and the diagnostic-RAM read path between the area-scan
// engines, starting each enabled engine in turn on every scan-cycle trigger.
module area_scan_sched #(
  parameter int AREA_NUM  = 4,
  parameter int TIMEOUT   = 64,
  parameter int DRAIN_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cycle_start,
  input  logic [AREA_NUM-1:0]   im_area_en,
  input  logic [12*AREA_NUM-1:0] im_base_tbl,
  output logic [AREA_NUM-1:0]   om_area_start,
  output logic [11:0]           om_area_base,
  input  logic [AREA_NUM-1:0]   im_area_done,
  input  logic [AREA_NUM-1:0]   im_area_wren,
  input  logic [15*AREA_NUM-1:0] im_area_addr,
  input  logic [8*AREA_NUM-1:0] im_area_din,
  output logic [2:0]            om_diag_sel,
  output logic                  o_cudb_wren,
  output logic [14:0]           om_cudb_addr,
  output logic [7:0]            om_cudb_din,
  output logic                  o_busy,
  output logic                  o_cycle_done,
  output logic [AREA_NUM-1:0]   om_timeout_err,
  output logic                  o_overrun
);
  // state   | meaning
  // IDLE    | waiting for a scan-cycle trigger
  // SEL     | pick lowest pending area, register its index and base
  // START   | issue the one-cycle start pulse
  // WAIT    | engine running, watch for done or timeout
  // DRAIN   | grant held while the engine write pipeline empties
  // DONE    | pulse cycle_done, back to IDLE
  localparam int CNT_MAX = (TIMEOUT > DRAIN_CYC) ? TIMEOUT : DRAIN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_SEL   = 6'b000010,
    S_START = 6'b000100,
    S_WAIT  = 6'b001000,
    S_DRAIN = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  state_t              state;
  logic [AREA_NUM-1:0] pending;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          sel_idx;
  logic [AREA_NUM-1:0] sel_hot;
  logic [11:0]         sel_base;
  logic [AREA_NUM-1:0] grant_hot;
  logic                grant;
  logic                g_wren;
  logic                g_done;
  logic [14:0]         g_addr;
  logic [7:0]          g_din;

  always_comb begin
    sel_idx  = '0;
    sel_hot  = '0;
    sel_base = '0;
    for (int i = AREA_NUM - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = 3'(i);
    end
    for (int i = 0; i < AREA_NUM; i++) begin
      if (sel_idx == 3'(i)) begin
        sel_hot[i] = 1'b1;
        sel_base   = im_base_tbl[12*i +: 12];
      end
    end
  end

  // Everything about the granted area is keyed off the registered diag select.
  always_comb begin
    grant_hot = '0;
    g_wren    = 1'b0;
    g_done    = 1'b0;
    g_addr    = '0;
    g_din     = '0;
    for (int i = 0; i < AREA_NUM; i++) begin
      if (om_diag_sel == 3'(i)) begin
        grant_hot[i] = 1'b1;
        g_wren       = im_area_wren[i];
        g_done       = im_area_done[i];
        g_addr       = im_area_addr[15*i +: 15];
        g_din        = im_area_din[8*i +: 8];
      end
    end
  end

  assign grant = (state == S_START) || (state == S_WAIT) || (state == S_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pending        <= '0;
      cnt            <= '0;
      om_area_start  <= '0;
      om_area_base   <= '0;
      om_diag_sel    <= '0;
      om_timeout_err <= '0;
      o_busy         <= 1'b0;
      o_cycle_done   <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      om_area_start <= '0;
      o_cycle_done  <= 1'b0;
      o_overrun     <= i_cycle_start && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (i_cycle_start) begin
            pending        <= im_area_en;
            om_timeout_err <= '0;
            o_busy         <= 1'b1;
            state          <= S_SEL;
          end
        end
        S_SEL: begin
          if (pending == '0) begin
            state <= S_DONE;
          end else begin
            pending      <= pending & ~sel_hot;
            om_diag_sel  <= sel_idx;
            om_area_base <= sel_base;
            state        <= S_START;
          end
        end
        S_START: begin
          om_area_start <= grant_hot;
          cnt           <= '0;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (g_done) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            om_timeout_err <= om_timeout_err | grant_hot;
            cnt            <= '0;
            state          <= S_DRAIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (cnt == CNT_W'(DRAIN_CYC - 1)) state <= S_SEL;
          else cnt <= cnt + CNT_W'(1);
        end
        S_DONE: begin
          o_cycle_done <= 1'b1;
          o_busy       <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cudb_wren  <= 1'b0;
      om_cudb_addr <= '0;
      om_cudb_din  <= '0;
    end else if (grant) begin
      o_cudb_wren  <= g_wren;
      om_cudb_addr <= g_addr;
      om_cudb_din  <= g_din;
    end else begin
      o_cudb_wren  <= 1'b0;
      om_cudb_addr <= '0;
      om_cudb_din  <= '0;
    end
  end
endmodule
